i2c_scan_sched: RTL and testbench
=================================

Name: i2c_scan_sched

Overview:
- Frame-synchronous scheduler that shares one I2C accelerometer read engine across up to 8 sensor channels.
- On each frame tick it walks the enabled channels in ascending order and issues one read per channel.
- It forwards each 48-bit x/y/z result to the per-channel sample store, then pulses frame_done, which starts the offset-elimination/sum chain.
- It handles NACK and timeout per channel, and reports frame overrun.

Parameters:
- N_CH, 8, number of channels; fixed at 8 in this revision (channel index width 3).
- TIMEOUT_CYC, 50000, clock cycles allowed from rd_ack to rd_done/rd_err before the channel is abandoned.
- TO_W, 16, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-low.
- frame_tick  in  1  one-cycle pulse from the frame-sync generator (100 Hz).
- ch_mask  in  8  channel enable, bit i = channel i. Sampled only at frame start.
- rd_req  out  1  read request to the I2C engine; held until rd_ack.
- rd_ch  out  3  channel being read; stable while rd_req=1 and until the result returns.
- rd_ack  in  1  engine accepted the request (one-cycle pulse).
- rd_done  in  1  one-cycle pulse, rd_data valid.
- rd_err  in  1  one-cycle pulse, NACK/bus error.
- rd_data  in  48  {x[15:0], y[15:0], z[15:0]} raw sensor words.
- wr_en  out  1  one-cycle write strobe to the sample store.
- wr_ch  out  3  store index.
- wr_data  out  48  data written.
- busy  out  1  high from frame start until frame_done.
- frame_done  out  1  one-cycle pulse at end of scan.
- err_flags  out  8  per-channel error for the last completed frame.
- overrun  out  1  sticky; set when frame_tick arrives while busy.
- ovr_clr  in  1  clears overrun. A set on the same cycle wins.

Behaviour:
- Reset (RST=0, async): state IDLE; all outputs 0; internal mask, channel pointer and timeout counter cleared.
- All outputs are registered.
- IDLE: on frame_tick, latch mask_q=ch_mask, clear the internal err_acc, set busy, ptr=0, go to SCAN.
  - If ch_mask==0: go to FIN directly (frame_done still pulses, err_flags=0).
- SCAN: find the lowest i >= ptr with mask_q[i]=1.
  - Found: rd_ch=i, rd_req=1, go to REQ.
  - None left: go to FIN.
  - The search costs exactly one cycle per SCAN entry (combinational priority search over 8 bits).
- REQ: hold rd_req and rd_ch.
  - On rd_ack: rd_req=0, clear the timeout counter, go to WAIT.
  - No timeout applies in REQ; the engine must acknowledge.
- WAIT: timeout counter increments every cycle.
  - rd_done: next cycle wr_en=1, wr_ch=rd_ch, wr_data=rd_data; ptr=rd_ch+1; go to SCAN.
  - rd_err: err_acc[rd_ch]=1, no write; ptr=rd_ch+1; go to SCAN.
  - Counter reaches TIMEOUT_CYC-1 with no response: err_acc[rd_ch]=1, no write, advance as for rd_err.
  - rd_done and rd_err in the same cycle: treated as error, no write.
  - rd_done/rd_err outside WAIT are ignored.
- Pointer wrap: ptr=8 (carry out of rd_ch+1) means no channels left, go to FIN. There is no wrap to 0 within a frame.
- FIN: one cycle.
  - err_flags <= err_acc; frame_done=1; busy=0; go to IDLE.
  - The last wr_en precedes frame_done by at least 1 cycle.
- frame_tick while busy (any state other than IDLE):
  - overrun <= 1; the tick is dropped; the current scan continues unaffected.
- frame_tick in the FIN cycle counts as an overrun.
- ovr_clr clears overrun unless a set occurs on the same cycle.
- Latency, per channel, for a zero-wait engine:
  - SCAN → REQ: 1 cycle.
  - rd_ack → WAIT: 1 cycle.
  - rd_done → wr_en: 1 cycle.
  - wr_en → next rd_req: 1 cycle.
- ch_mask changes mid-frame have no effect until the next frame start.

Decomposition:
- Shared package holds:
  - state encoding: IDLE, SCAN, REQ, WAIT, FIN;
  - N_CH = 8, CH_W = 3;
  - SAMPLE_W = 48;
  - field offsets for x/y/z within the 48-bit word, shared with the sample store and the offset-elimination stage.
- One sub-module, ch_prio_pick: 8-bit mask plus 3-bit start pointer in, {found, idx} out. It is purely combinational and separately unit-testable.
- Timeout counter and FSM stay in the top.

Test Plan:
- Full scan: ch_mask=8'hFF, engine acks in 1 cycle and returns rd_done after 10 cycles with rd_data={16'h0100·i, 16'h0200·i, 16'h0300·i} → 8 wr_en pulses with wr_ch 0..7 and matching data; frame_done once after the last write; err_flags=8'h00; busy falls with frame_done.
- Sparse mask: ch_mask=8'b1010_0101 → reads only on channels 0, 2, 5, 7 in that order. Change ch_mask to 8'hFF mid-frame → no extra reads this frame; all 8 channels are read next frame.
- Errors: channel 3 returns rd_err, channel 6 never responds (TIMEOUT_CYC=100) → no wr_en for 3 or 6; channel 6 advances exactly 100 cycles after its rd_ack; err_flags=8'b0100_1000 after frame_done.
- Overrun: second frame_tick during WAIT of channel 4 → overrun=1, scan completes normally, one frame_done only. Assert ovr_clr with no tick → overrun=0. Assert ovr_clr together with a new overrun tick → overrun stays 1.
- Empty mask / boundary: ch_mask=0 → frame_done 2 cycles after frame_tick, no rd_req. Same-cycle rd_done+rd_err on channel 0 → no write, err_flags[0]=1.
- Reset mid-operation: drop RST during WAIT → rd_req, wr_en, busy, frame_done, err_flags and overrun all 0 immediately (asynchronously). After release, the next frame_tick starts a clean scan from channel 0.

Source files
------------

// File: rtl/i2c_scan_sched_pkg.sv
// Shared types and constants for the I2C accelerometer scan scheduler,
// the per-channel sample store and the offset-elimination stage.
package i2c_scan_sched_pkg;

  localparam int N_CH     = 8;
  localparam int CH_W     = 3;
  localparam int SAMPLE_W = 48;
  localparam int FIELD_W  = 16;
  localparam int X_LSB    = 32;
  localparam int Y_LSB    = 16;
  localparam int Z_LSB    = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  function automatic logic [SAMPLE_W-1:0] pack_xyz(
    input logic [FIELD_W-1:0] x,
    input logic [FIELD_W-1:0] y,
    input logic [FIELD_W-1:0] z
  );
    logic [SAMPLE_W-1:0] s;
    s = {SAMPLE_W{1'b0}};
    s[X_LSB +: FIELD_W] = x;
    s[Y_LSB +: FIELD_W] = y;
    s[Z_LSB +: FIELD_W] = z;
    return s;
  endfunction

endpackage

// File: rtl/i2c_scan_sched_ch_prio_pick.sv
// Combinational picker: lowest enabled channel index at or above a start pointer.
module ch_prio_pick
  import i2c_scan_sched_pkg::*;
(
  input  logic [N_CH-1:0] mask,
  input  logic [CH_W-1:0] start,
  output logic            found,
  output logic [CH_W-1:0] idx
);

  logic [N_CH-1:0] hit_s;

  // Mask off channels below start, then take the lowest remaining bit
  always_comb begin
    hit_s = mask & ({N_CH{1'b1}} << start);
    found = 1'b0;
    idx   = {CH_W{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      idx   = (hit_s[i] && !found) ? CH_W'(i) : idx;
      found = found | hit_s[i];
    end
  end

endmodule

// File: rtl/i2c_scan_sched.sv
// Frame-synchronous scheduler sharing one I2C read engine across 8 sensor
// channels; forwards samples to the store and reports errors and overrun.
module i2c_scan_sched
  import i2c_scan_sched_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int TO_W        = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                frame_tick,
  input  logic [N_CH-1:0]     ch_mask,
  output logic                rd_req,
  output logic [CH_W-1:0]     rd_ch,
  input  logic                rd_ack,
  input  logic                rd_done,
  input  logic                rd_err,
  input  logic [SAMPLE_W-1:0] rd_data,
  output logic                wr_en,
  output logic [CH_W-1:0]     wr_ch,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic                busy,
  output logic                frame_done,
  output logic [N_CH-1:0]     err_flags,
  output logic                overrun,
  input  logic                ovr_clr
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t          state_r;
  logic [N_CH-1:0] mask_r;
  logic [N_CH-1:0] err_acc_r;
  logic [CH_W:0]   ptr_r;
  logic [TO_W-1:0] to_cnt_r;
  logic            pick_found_s;
  logic [CH_W-1:0] pick_idx_s;
  logic [CH_W:0]   next_ptr_s;

  // Extra MSB carries out past channel 7 so the scan ends without wrapping
  assign next_ptr_s = {1'b0, rd_ch} + {{CH_W{1'b0}}, 1'b1};

  ch_prio_pick u_pick (
    .mask  (mask_r),
    .start (ptr_r[CH_W-1:0]),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Scan FSM, timeout counter and all registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r    <= ST_IDLE;
      mask_r     <= {N_CH{1'b0}};
      err_acc_r  <= {N_CH{1'b0}};
      ptr_r      <= {(CH_W+1){1'b0}};
      to_cnt_r   <= {TO_W{1'b0}};
      rd_req     <= 1'b0;
      rd_ch      <= {CH_W{1'b0}};
      wr_en      <= 1'b0;
      wr_ch      <= {CH_W{1'b0}};
      wr_data    <= {SAMPLE_W{1'b0}};
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err_flags  <= {N_CH{1'b0}};
      overrun    <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;

      // A tick outside IDLE (FIN included) is dropped and flagged; set beats clear
      if (frame_tick && (state_r != ST_IDLE)) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end else begin
        overrun <= overrun;
      end

      case (state_r)
        ST_IDLE: begin
          if (frame_tick) begin
            mask_r    <= ch_mask;
            err_acc_r <= {N_CH{1'b0}};
            busy      <= 1'b1;
            ptr_r     <= {(CH_W+1){1'b0}};
            state_r   <= (ch_mask == {N_CH{1'b0}}) ? ST_FIN : ST_SCAN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (!ptr_r[CH_W] && pick_found_s) begin
            rd_ch   <= pick_idx_s;
            rd_req  <= 1'b1;
            state_r <= ST_REQ;
          end else begin
            state_r <= ST_FIN;
          end
        end
        ST_REQ: begin
          if (rd_ack) begin
            rd_req   <= 1'b0;
            to_cnt_r <= {TO_W{1'b0}};
            state_r  <= ST_WAIT;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_WAIT: begin
          // Error wins over a simultaneous done; a response on the last cycle still counts
          if (rd_err) begin
            err_acc_r[rd_ch] <= 1'b1;
            ptr_r            <= next_ptr_s;
            state_r          <= ST_SCAN;
          end else if (rd_done) begin
            wr_en   <= 1'b1;
            wr_ch   <= rd_ch;
            wr_data <= rd_data;
            ptr_r   <= next_ptr_s;
            state_r <= ST_SCAN;
          end else if (to_cnt_r == TO_LAST) begin
            err_acc_r[rd_ch] <= 1'b1;
            ptr_r            <= next_ptr_s;
            state_r          <= ST_SCAN;
          end else begin
            to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
          end
        end
        ST_FIN: begin
          err_flags  <= err_acc_r;
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_scan_sched.sv
// Self-checking bench: behavioural I2C engine, read-order and write scoreboards,
// and one task per scenario.
module tb_i2c_scan_sched;
  import i2c_scan_sched_pkg::*;

  localparam int TO_CYC = 100;

  typedef enum int {R_DONE, R_ERR, R_NONE, R_BOTH} resp_t;

  logic                CLK = 1'b0;
  logic                RST = 1'b0;
  logic                frame_tick = 1'b0;
  logic [N_CH-1:0]     ch_mask = '0;
  logic                rd_req;
  logic [CH_W-1:0]     rd_ch;
  logic                rd_ack;
  logic                rd_done;
  logic                rd_err;
  logic [SAMPLE_W-1:0] rd_data;
  logic                wr_en;
  logic [CH_W-1:0]     wr_ch;
  logic [SAMPLE_W-1:0] wr_data;
  logic                busy;
  logic                frame_done;
  logic [N_CH-1:0]     err_flags;
  logic                overrun;
  logic                ovr_clr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int fd_count = 0;
  int t_ack6 = -1;
  int t_req7 = -1;

  resp_t              resp_mode [N_CH];
  logic [CH_W-1:0]    exp_rd_q [$];
  logic [CH_W+SAMPLE_W-1:0] exp_wr_q [$];

  bit         eng_busy = 1'b0;
  int         eng_cnt  = 0;
  logic [CH_W-1:0] eng_cur = '0;

  i2c_scan_sched #(.TIMEOUT_CYC(TO_CYC), .TO_W(16)) dut (
    .CLK(CLK), .RST(RST), .frame_tick(frame_tick), .ch_mask(ch_mask),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_ack(rd_ack), .rd_done(rd_done),
    .rd_err(rd_err), .rd_data(rd_data), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_data(wr_data), .busy(busy), .frame_done(frame_done),
    .err_flags(err_flags), .overrun(overrun), .ovr_clr(ovr_clr)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [SAMPLE_W-1:0] sample_for(input int ch);
    logic [FIELD_W-1:0] x, y, z;
    x = 16'(32'h0100 * ch);
    y = 16'(32'h0200 * ch);
    z = 16'(32'h0300 * ch);
    return pack_xyz(x, y, z);
  endfunction

  // Engine model: acks at once, answers 10 cycles later per resp_mode
  initial begin
    logic [CH_W-1:0] exp_ch;
    rd_ack = 1'b0; rd_done = 1'b0; rd_err = 1'b0; rd_data = '0;
    forever begin
      @(negedge CLK);
      rd_ack = 1'b0; rd_done = 1'b0; rd_err = 1'b0;
      if (!RST) begin
        eng_busy = 1'b0;
      end else if (!eng_busy) begin
        if (rd_req) begin
          eng_cur = rd_ch;
          n_checks++;
          if (exp_rd_q.size() == 0) begin
            n_errors++;
            $display("FAIL rd_order: read of ch %0d, required none", rd_ch);
          end else begin
            exp_ch = exp_rd_q.pop_front();
            if (rd_ch !== exp_ch) begin
              n_errors++;
              $display("FAIL rd_order: rd_ch=%0d required %0d", rd_ch, exp_ch);
            end
          end
          if (eng_cur == 3'd6) t_ack6 = cyc;
          if (eng_cur == 3'd7) t_req7 = cyc;
          rd_ack = 1'b1; eng_busy = 1'b1; eng_cnt = 0;
        end
      end else begin
        eng_cnt++;
        if (resp_mode[eng_cur] == R_NONE) begin
          eng_busy = 1'b0;
        end else if (eng_cnt == 10) begin
          rd_done = (resp_mode[eng_cur] != R_ERR);
          rd_err  = (resp_mode[eng_cur] != R_DONE);
          rd_data = sample_for(int'(eng_cur));
          eng_busy = 1'b0;
        end
      end
    end
  end

  // Output monitor: write scoreboard and frame_done bookkeeping
  initial begin
    logic [CH_W+SAMPLE_W-1:0] e;
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        if (wr_en) begin
          n_checks++;
          if (exp_wr_q.size() == 0) begin
            n_errors++;
            $display("FAIL wr: write ch %0d data %h, required none", wr_ch, wr_data);
          end else begin
            e = exp_wr_q.pop_front();
            if ({wr_ch, wr_data} !== e) begin
              n_errors++;
              $display("FAIL wr: got ch %0d data %h required ch %0d data %h",
                       wr_ch, wr_data, e[SAMPLE_W +: CH_W], e[SAMPLE_W-1:0]);
            end
          end
        end
        if (frame_done) begin
          fd_count++;
          n_checks++;
          if (busy !== 1'b0 || prev_busy !== 1'b1 || exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
            n_errors++;
            $display("FAIL frame_end: busy=%b prev_busy=%b reads_left=%0d writes_left=%0d, required 0 1 0 0",
                     busy, prev_busy, exp_rd_q.size(), exp_wr_q.size());
          end
        end
      end
      prev_busy = busy;
    end
  end

  task automatic set_modes_done();
    for (int i = 0; i < N_CH; i++) resp_mode[i] = R_DONE;
  endtask

  // Expected reads in ascending channel order; writes only for non-error channels
  task automatic push_frame(input logic [N_CH-1:0] m, input logic [N_CH-1:0] bad);
    for (int i = 0; i < N_CH; i++) begin
      if (m[i]) begin
        exp_rd_q.push_back(CH_W'(i));
        if (!bad[i]) exp_wr_q.push_back({CH_W'(i), sample_for(i)});
      end
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge CLK);
    frame_tick = 1'b0;
  endtask

  task automatic wait_done(input int start, input int budget, output bit ok);
    int k;
    k = 0;
    while (fd_count == start && k < budget) begin
      @(negedge CLK);
      k++;
    end
    @(negedge CLK);
    ok = (fd_count != start);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({rd_req, wr_en, busy, frame_done, err_flags, overrun, rd_ch, wr_ch, wr_data} !== '0) begin
      n_errors++;
      $display("FAIL reset_in: outputs not all zero (rd_req=%b wr_en=%b busy=%b err=%h ovr=%b)",
               rd_req, wr_en, busy, err_flags, overrun);
    end
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({rd_req, wr_en, busy, frame_done, err_flags, overrun} !== '0) begin
      n_errors++;
      $display("FAIL reset_idle: outputs not zero after release (rd_req=%b busy=%b)", rd_req, busy);
    end
  endtask

  task automatic test_full_scan();
    int start; bit ok;
    set_modes_done();
    ch_mask = 8'hFF;
    push_frame(8'hFF, 8'h00);
    start = fd_count;
    tick();
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL full_busy: busy=%b required 1", busy); end
    wait_done(start, 400, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL full_done: no frame_done within budget"); end
    n_checks++;
    if (err_flags !== 8'h00) begin n_errors++; $display("FAIL full_err: err_flags=%h required 00", err_flags); end
    repeat (5) @(negedge CLK);
    n_checks++;
    if (fd_count != start + 1) begin n_errors++; $display("FAIL full_fd_count: %0d frames required 1", fd_count - start); end
  endtask

  task automatic test_sparse();
    int start; bit ok;
    set_modes_done();
    ch_mask = 8'b1010_0101;
    push_frame(8'b1010_0101, 8'h00);
    start = fd_count;
    tick();
    repeat (5) @(negedge CLK);
    ch_mask = 8'hFF;
    wait_done(start, 400, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL sparse_done: no frame_done within budget"); end
    push_frame(8'hFF, 8'h00);
    start = fd_count;
    tick();
    wait_done(start, 400, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL sparse_next_done: no frame_done within budget"); end
  endtask

  task automatic test_errors();
    int start; bit ok;
    set_modes_done();
    resp_mode[3] = R_ERR;
    resp_mode[6] = R_NONE;
    t_ack6 = -1; t_req7 = -1;
    ch_mask = 8'hFF;
    push_frame(8'hFF, 8'b0100_1000);
    start = fd_count;
    tick();
    wait_done(start, 800, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL err_done: no frame_done within budget"); end
    n_checks++;
    if (err_flags !== 8'b0100_1000) begin n_errors++; $display("FAIL err_flags: err_flags=%h required 48", err_flags); end
    // TO_CYC cycles of WAIT after the ack edge, then one SCAN cycle, seen at the following negedge
    n_checks++;
    if (t_req7 - t_ack6 != TO_CYC + 2) begin
      n_errors++;
      $display("FAIL err_timeout: ack6->req7=%0d cycles required %0d", t_req7 - t_ack6, TO_CYC + 2);
    end
    set_modes_done();
  endtask

  task automatic test_empty();
    ch_mask = 8'h00;
    tick();
    n_checks++;
    if (frame_done !== 1'b0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL empty_c1: frame_done=%b busy=%b required 0 1", frame_done, busy);
    end
    @(negedge CLK);
    n_checks++;
    if (frame_done !== 1'b1) begin n_errors++; $display("FAIL empty_c2: frame_done=%b required 1", frame_done); end
    n_checks++;
    if (err_flags !== 8'h00) begin n_errors++; $display("FAIL empty_err: err_flags=%h required 00", err_flags); end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_both();
    int start; bit ok;
    set_modes_done();
    resp_mode[0] = R_BOTH;
    ch_mask = 8'h01;
    push_frame(8'h01, 8'h01);
    start = fd_count;
    tick();
    wait_done(start, 200, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL both_done: no frame_done within budget"); end
    n_checks++;
    if (err_flags !== 8'h01) begin n_errors++; $display("FAIL both_err: err_flags=%h required 01", err_flags); end
    set_modes_done();
  endtask

  task automatic test_overrun();
    int start, k; bit ok;
    set_modes_done();
    ch_mask = 8'hFF;
    push_frame(8'hFF, 8'h00);
    start = fd_count;
    tick();
    k = 0;
    while (!(eng_busy && eng_cur == 3'd4) && k < 300) begin @(negedge CLK); k++; end
    n_checks++;
    if (!(eng_busy && eng_cur == 3'd4)) begin n_errors++; $display("FAIL ovr_reach: ch 4 WAIT not reached"); end
    tick();
    n_checks++;
    if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_set: overrun=%b required 1", overrun); end
    wait_done(start, 400, ok);
    repeat (20) @(negedge CLK);
    n_checks++;
    if (fd_count != start + 1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL ovr_one_frame: frames=%0d busy=%b required 1 0", fd_count - start, busy);
    end
    ovr_clr = 1'b1;
    @(negedge CLK);
    ovr_clr = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin n_errors++; $display("FAIL ovr_clr: overrun=%b required 0", overrun); end
    // Second frame: clear and new overrun together, channel 1 errors for later reset check
    resp_mode[1] = R_ERR;
    push_frame(8'hFF, 8'h02);
    start = fd_count;
    tick();
    frame_tick = 1'b1; ovr_clr = 1'b1;
    @(negedge CLK);
    frame_tick = 1'b0; ovr_clr = 1'b0;
    n_checks++;
    if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_set_wins: overrun=%b required 1", overrun); end
    wait_done(start, 400, ok);
    n_checks++;
    if (!ok || err_flags !== 8'h02) begin
      n_errors++;
      $display("FAIL ovr_frame2: done=%b err_flags=%h required 1 02", ok, err_flags);
    end
    set_modes_done();
  endtask

  task automatic test_reset_mid();
    int start, k; bit ok;
    n_checks++;
    if (overrun !== 1'b1 || err_flags !== 8'h02) begin
      n_errors++;
      $display("FAIL rst_pre: overrun=%b err_flags=%h required 1 02", overrun, err_flags);
    end
    set_modes_done();
    ch_mask = 8'hFF;
    push_frame(8'hFF, 8'h00);
    tick();
    k = 0;
    while (!(eng_busy && eng_cur == 3'd2) && k < 300) begin @(negedge CLK); k++; end
    #2;
    RST = 1'b0;
    #1;
    n_checks++;
    if ({rd_req, wr_en, busy, frame_done, err_flags, overrun} !== '0) begin
      n_errors++;
      $display("FAIL rst_async: rd_req=%b wr_en=%b busy=%b fd=%b err=%h ovr=%b required all 0",
               rd_req, wr_en, busy, frame_done, err_flags, overrun);
    end
    exp_rd_q.delete();
    exp_wr_q.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    push_frame(8'hFF, 8'h00);
    start = fd_count;
    tick();
    wait_done(start, 400, ok);
    n_checks++;
    if (!ok || err_flags !== 8'h00) begin
      n_errors++;
      $display("FAIL rst_rescan: done=%b err_flags=%h required 1 00", ok, err_flags);
    end
  endtask

  initial begin
    set_modes_done();
    @(negedge CLK);
    test_reset();
    test_full_scan();
    test_sparse();
    test_errors();
    test_empty();
    test_both();
    test_overrun();
    test_reset_mid();
    repeat (5) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
